// File: rtl/axi_read_arbiter_pkg.sv
// rtl/axi_read_arbiter_pkg.sv - shared types and AXI constants for the refill read arbiter
package axi_read_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    localparam logic [3:0] IC_ID_DEFAULT = 4'd0;
    localparam logic [3:0] DC_ID_DEFAULT = 4'd1;

    // Clear the byte offset within a cache line (line_bytes is a power of two)
    function automatic logic [31:0] line_align(input logic [31:0] addr,
                                               input logic [31:0] line_bytes);
        return addr & ~(line_bytes - 32'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin pick with last-grant register
module rr_arbiter_2 (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic req_ic,
    input  logic req_dc,
    input  logic update,
    input  logic update_dc,
    output logic grant_ic,
    output logic grant_dc
);

    // 1 when the DCache owned the most recent completed burst
    logic last_dc;

    // On a tie the requester that did not win last time gets the grant
    always_comb begin
        grant_ic = enable && req_ic && (!req_dc || last_dc);
        grant_dc = enable && req_dc && (!req_ic || !last_dc);
    end

    // Last-grant history moves only when a burst finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dc <= 1'b1;
        end else if (update) begin
            last_dc <= update_dc;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - arbitrates ICache/DCache line refills onto one AXI read master
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 8,
    parameter logic [3:0]  IC_ID      = IC_ID_DEFAULT,
    parameter logic [3:0]  DC_ID      = DC_ID_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ic_req_valid,
    input  logic [31:0] ic_req_addr,
    output logic        ic_req_ready,
    output logic        ic_resp_valid,
    output logic [31:0] ic_resp_data,
    output logic        ic_resp_last,

    input  logic        dc_req_valid,
    input  logic [31:0] dc_req_addr,
    output logic        dc_req_ready,
    output logic        dc_resp_valid,
    output logic [31:0] dc_resp_data,
    output logic        dc_resp_last,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic        err
);

    localparam int unsigned     CNT_W      = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [31:0]      LINE_BYTES = 32'(LINE_WORDS * 4);

    state_t           state_q, state_d;
    logic [31:0]      addr_q;
    logic             sel_dc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic grant_ic, grant_dc, arb_enable;
    logic beat_ok, final_beat, beat_bad;

    // Grants are only possible in IDLE and never while reset is held
    assign arb_enable = (state_q == ST_IDLE) && rst_n;

    rr_arbiter_2 u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (arb_enable),
        .req_ic    (ic_req_valid),
        .req_dc    (dc_req_valid),
        .update    (final_beat),
        .update_dc (sel_dc_q),
        .grant_ic  (grant_ic),
        .grant_dc  (grant_dc)
    );

    assign ic_req_ready = grant_ic;
    assign dc_req_ready = grant_dc;

    assign arid    = sel_dc_q ? DC_ID : IC_ID;
    assign araddr  = addr_q;
    assign arlen   = 8'(LINE_WORDS - 1);
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;

    assign ic_resp_data = rdata;
    assign dc_resp_data = rdata;
    assign err          = err_q;

    assign beat_ok    = (state_q == ST_DATA) && rvalid;
    assign final_beat = beat_ok && (cnt_q == LAST_BEAT);
    assign beat_bad   = (rresp != 2'b00) || (rid != arid) || (rlast != (cnt_q == LAST_BEAT));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; beats pass straight through to the owner
    always_comb begin
        state_d       = state_q;
        arvalid       = 1'b0;
        rready        = 1'b0;
        ic_resp_valid = 1'b0;
        dc_resp_valid = 1'b0;
        ic_resp_last  = 1'b0;
        dc_resp_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_ic || grant_dc) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                rready        = 1'b1;
                ic_resp_valid = rvalid && !sel_dc_q;
                dc_resp_valid = rvalid && sel_dc_q;
                ic_resp_last  = final_beat && !sel_dc_q;
                dc_resp_last  = final_beat && sel_dc_q;
                if (final_beat) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Burst context, beat counter and sticky error; errors never change sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= 32'd0;
            sel_dc_q <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (grant_ic || grant_dc) begin
                addr_q   <= line_align(grant_dc ? dc_req_addr : ic_req_addr, LINE_BYTES);
                sel_dc_q <= grant_dc;
            end
            if (state_q == ST_ADDR && arready) begin
                cnt_q <= '0;
            end else if (beat_ok) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (beat_ok && beat_bad) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - scoreboard bench for axi_read_arbiter
module tb_axi_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ic_req_valid, ic_req_ready, ic_resp_valid, ic_resp_last;
    logic [31:0] ic_req_addr, ic_resp_data;
    logic        dc_req_valid, dc_req_ready, dc_resp_valid, dc_resp_last;
    logic [31:0] dc_req_addr, dc_resp_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        err;

    typedef struct packed {
        logic        is_dc;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    total = 0;
    int    bad   = 0;

    axi_read_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_resp_last(ic_resp_last),
        .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_ready(dc_req_ready),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .dc_resp_last(dc_resp_last),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every forwarded beat must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (ic_resp_valid === 1'b1 || dc_resp_valid === 1'b1)) begin
            if (ic_resp_valid === 1'b1 && dc_resp_valid === 1'b1) begin
                total++;
                bad++;
                $display("FAIL resp_both actual=both valid required=one valid");
            end else if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_unexpected actual=beat required=no beat");
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_sel", {31'd0, dc_resp_valid}, {31'd0, mon_e.is_dc});
                check("resp_data", mon_e.is_dc ? dc_resp_data : ic_resp_data, mon_e.data);
                check("resp_last", {31'd0, mon_e.is_dc ? dc_resp_last : ic_resp_last},
                      {31'd0, mon_e.last});
                check("resp_last_other", {31'd0, mon_e.is_dc ? ic_resp_last : dc_resp_last}, 0);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Single requester: ready must come back in the same cycle
    task automatic issue(input bit to_dc, input logic [31:0] addr);
        @(posedge clk); #1;
        if (to_dc) begin dc_req_valid = 1'b1; dc_req_addr = addr; end
        else       begin ic_req_valid = 1'b1; ic_req_addr = addr; end
        @(negedge clk);
        check("grant_ready", {30'd0, dc_req_ready, ic_req_ready}, to_dc ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        if (to_dc) dc_req_valid = 1'b0;
        else       ic_req_valid = 1'b0;
    endtask

    // AXI slave: accepts the address after ar_delay stalled cycles, returns 8 beats
    task automatic serve(input logic [3:0] id, input logic [31:0] addr, input bit to_dc,
                         input int ar_delay, input bit gaps, input int bad_resp_beat,
                         input int bad_last_beat, input int abort_beat);
        int          i;
        bit          found;
        beat_t       e;
        logic [31:0] dval;
        found = 1'b0;
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arvalid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL ar_timeout actual=no arvalid required=arvalid");
            return;
        end
        check("ar_latency", i, 0);
        for (int d = 0; d < ar_delay; d++) begin
            check("arvalid_hold", {31'd0, arvalid}, 1);
            check("araddr_hold", araddr, addr);
            check("arlen_hold", {24'd0, arlen}, 7);
            check("rready_pre", {31'd0, rready}, 0);
            @(negedge clk);
        end
        check("arvalid", {31'd0, arvalid}, 1);
        check("araddr", araddr, addr);
        check("arlen", {24'd0, arlen}, 7);
        check("arid", {28'd0, arid}, {28'd0, id});
        check("arsize_burst", {27'd0, arsize, arburst}, {27'd0, 3'b010, 2'b01});
        check("req_ready_busy", {30'd0, dc_req_ready, ic_req_ready}, 0);
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (gaps) begin
                repeat (b % 3) begin
                    @(negedge clk);
                    check("gap_no_resp", {30'd0, ic_resp_valid, dc_resp_valid}, 0);
                    @(posedge clk); #1;
                end
            end
            dval   = {16'hC0DE, 4'h0, id, 8'(b)};
            rdata  = dval;
            rid    = id;
            rresp  = (b == bad_resp_beat) ? 2'b10 : 2'b00;
            rlast  = (b == 7) != (b == bad_last_beat);
            rvalid = 1'b1;
            if (b == abort_beat) begin
                rst_n = 1'b0;
                #1;
                check("rst_outputs",
                      {24'd0, arvalid, rready, ic_req_ready, dc_req_ready,
                       ic_resp_valid, dc_resp_valid, ic_resp_last | dc_resp_last, err}, 0);
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            e.is_dc = to_dc;
            e.data  = dval;
            e.last  = (b == 7);
            exp_q.push_back(e);
            @(negedge clk);
            check("rready_beat", {31'd0, rready}, 1);
            check("req_ready_data", {30'd0, dc_req_ready, ic_req_ready}, 0);
            check("err_before", {31'd0, err},
                  {31'd0, (bad_resp_beat >= 0 && b > bad_resp_beat) ||
                          (bad_last_beat >= 0 && b > bad_last_beat)});
            @(posedge clk); #1;
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
            if (b == bad_resp_beat || b == bad_last_beat) check("err_set", {31'd0, err}, 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ic_req_valid = 1'b1; ic_req_addr = 32'h0; dc_req_valid = 1'b1; dc_req_addr = 32'h0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {24'd0, arvalid, rready, ic_req_ready, dc_req_ready,
               ic_resp_valid, dc_resp_valid, ic_resp_last | dc_resp_last, err}, 0);
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        rst_n = 1'b1;

        // ICache alone, address 0x114 aligns to 0x100
        issue(1'b0, 32'h0000_0114);
        serve(4'd0, 32'h0000_0100, 1'b0, 0, 1'b0, -1, -1, -1);

        // Last grant was IC, so a tie now goes to DC; IC follows after one IDLE cycle
        @(posedge clk); #1;
        ic_req_valid = 1'b1; ic_req_addr = 32'h0000_0C3C;
        dc_req_valid = 1'b1; dc_req_addr = 32'h0000_0A08;
        @(negedge clk);
        check("rr_tie_dc", {30'd0, dc_req_ready, ic_req_ready}, 2);
        @(posedge clk); #1;
        dc_req_valid = 1'b0;
        serve(4'd1, 32'h0000_0A00, 1'b1, 0, 1'b0, -1, -1, -1);
        @(negedge clk);
        check("rr_next_ic", {30'd0, dc_req_ready, ic_req_ready}, 1);
        @(posedge clk); #1;
        ic_req_valid = 1'b0;
        serve(4'd0, 32'h0000_0C20, 1'b0, 0, 1'b0, -1, -1, -1);

        // After reset the first tie goes to IC, then DC in the IDLE cycle after
        do_reset();
        @(posedge clk); #1;
        ic_req_valid = 1'b1; ic_req_addr = 32'h2000_0040;
        dc_req_valid = 1'b1; dc_req_addr = 32'h3000_007C;
        @(negedge clk);
        check("tie_after_reset", {30'd0, dc_req_ready, ic_req_ready}, 1);
        @(posedge clk); #1;
        ic_req_valid = 1'b0;
        serve(4'd0, 32'h2000_0040, 1'b0, 0, 1'b0, -1, -1, -1);
        @(negedge clk);
        check("dc_after_ic", {30'd0, dc_req_ready, ic_req_ready}, 2);
        @(posedge clk); #1;
        dc_req_valid = 1'b0;
        serve(4'd1, 32'h3000_0060, 1'b1, 0, 1'b0, -1, -1, -1);
        check("err_clean", {31'd0, err}, 0);

        // Address stall for 5 cycles
        issue(1'b0, 32'h0000_1000);
        serve(4'd0, 32'h0000_1000, 1'b0, 5, 1'b0, -1, -1, -1);

        // rvalid gaps on a DCache burst
        issue(1'b1, 32'h0000_2024);
        serve(4'd1, 32'h0000_2020, 1'b1, 0, 1'b1, -1, -1, -1);
        check("err_after_gaps", {31'd0, err}, 0);

        // SLVERR on beat 3
        do_reset();
        issue(1'b0, 32'h0000_3000);
        serve(4'd0, 32'h0000_3000, 1'b0, 0, 1'b0, 2, -1, -1);
        @(negedge clk);
        check("err_sticky_resp", {31'd0, err}, 1);

        // Early rlast on beat 6
        do_reset();
        @(negedge clk);
        check("err_cleared", {31'd0, err}, 0);
        issue(1'b0, 32'h0000_3100);
        serve(4'd0, 32'h0000_3100, 1'b0, 0, 1'b0, -1, 5, -1);
        @(negedge clk);
        check("err_sticky_last", {31'd0, err}, 1);

        // Reset during beat 4, then a normal refill
        do_reset();
        issue(1'b0, 32'h0000_4000);
        serve(4'd0, 32'h0000_4000, 1'b0, 0, 1'b0, -1, -1, 3);
        issue(1'b0, 32'h0000_5008);
        serve(4'd0, 32'h0000_5000, 1'b0, 0, 1'b0, -1, -1, -1);
        check("err_after_abort", {31'd0, err}, 0);

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameter LINE_WORDS, default 8: 32-bit words per cache-line burst; power of two, 2..16.
REQ-002 Parameter IC_ID, default 4'd0: AXI ID used for ICache refills.
REQ-003 Parameter DC_ID, default 4'd1: AXI ID used for DCache refills.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Port clk  in  1  clock; all logic on its rising edge.
REQ-006 Port rst_n  in  1  asynchronous active-low reset.
REQ-007 Port ic_req_valid / ic_req_addr  in  1 / 32  ICache refill request and byte address.
REQ-008 Port ic_req_ready  out  1  ICache request accepted this cycle.
REQ-009 Port ic_resp_valid / ic_resp_data / ic_resp_last  out  1 / 32 / 1  ICache refill beat, data, final beat.
REQ-010 Ports dc_req_valid, dc_req_addr, dc_req_ready, dc_resp_valid, dc_resp_data, dc_resp_last: as REQ-007..009, for the DCache.
REQ-011 Ports arid, araddr, arlen, arsize, arburst, arvalid  out  4, 32, 8, 3, 2, 1  AXI read-address master.
REQ-012 Port arready  in  1  AXI slave address acceptance.
REQ-013 Ports rid, rdata, rresp, rlast, rvalid  in  4, 32, 2, 1, 1  AXI read-data; rready  out  1.
REQ-014 Port err  out  1  sticky protocol/response error flag.

Function
REQ-015 The FSM SHALL have states IDLE, ADDR and DATA.
REQ-016 In IDLE with exactly one req_valid, that requester SHALL be granted; if both are valid, the one not granted last SHALL be granted (round-robin).
REQ-017 Grant cycle: the granted req_ready SHALL be 1 combinationally; the address is latched with its low log2(LINE_WORDS*4) bits cleared; next state is ADDR.
REQ-018 req_ready SHALL be 0 in every state other than IDLE.
REQ-019 ADDR: arvalid=1; araddr=latched address; arlen=LINE_WORDS-1; arsize=3'b010; arburst=2'b01 (INCR); arid=granted ID; all held stable until arready.
REQ-020 ADDR with arready=1: move to DATA and clear the beat counter to 0.
REQ-021 DATA: rready=1; each rvalid beat SHALL be forwarded combinationally, in the same cycle, to the granted requester's resp_valid/resp_data; the other requester's resp_valid stays 0.
REQ-022 Requesters SHALL NOT back-pressure responses; every forwarded beat counts as consumed.
REQ-023 The beat counter SHALL increment on each accepted beat; on the beat where count==LINE_WORDS-1, resp_last=1, the FSM returns to IDLE and last-grant is updated.
REQ-024 err SHALL be set, and stays set until reset, on any accepted beat where: rresp!=0; rid differs from the granted ID; or rlast differs from (count==LINE_WORDS-1).
REQ-025 An error SHALL NOT alter sequencing; termination is by beat count only.
REQ-026 Minimum latency: accept in cycle 0, arvalid in cycle 1, first beat forwarded in the cycle the slave presents it.
REQ-027 The earliest next grant SHALL be the cycle after a final beat (one IDLE cycle between bursts).

Reset
REQ-028 While rst_n=0: FSM=IDLE; arvalid, rready, both req_ready, both resp_valid, both resp_last and err = 0; last-grant=DC, so ICache wins the first tie.
REQ-029 Reset asserted mid-burst SHALL abandon the transaction without issuing further beats; the AXI slave shares the same reset.

Structure
REQ-030 A shared package SHALL hold the state enum, the AXI burst/size constants (INCR, 4-byte) and the default requester IDs.
REQ-031 A single sub-module rr_arbiter_2 SHALL implement the two-way round-robin pick and the last-grant register; all other logic is in axi_read_arbiter.

Verification
REQ-032 Only ic_req_valid, ic_req_addr=32'h00000114 -> ic_req_ready in cycle 0; araddr=32'h00000100, arlen=7, arid=0 in cycle 1; 8 ic_resp beats, last flagged on the 8th.
REQ-033 Both requests valid in the same cycle after reset -> ICache granted first; DCache granted in the IDLE cycle after the ICache's 8th beat, with arid=1.
REQ-034 Slave holds arready low for 5 cycles -> arvalid/araddr/arlen stable all 5 cycles; no rready before the handshake.
REQ-035 Slave inserts random rvalid gaps -> beats delivered in order, counter unaffected, resp_last only on the 8th valid beat.
REQ-036 Slave returns rresp=2'b10 on beat 3, or rlast on beat 6 -> err=1 from the next cycle; burst still completes after 8 beats.
REQ-037 rst_n pulsed low during beat 4 -> all outputs 0 at once; a fresh ICache request afterwards completes normally.
